// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port RAM between fetch and data requesters; define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dt_req,
  input  logic          dt_wr,
  input  logic [AW-1:0] dt_addr,
  input  logic [DW-1:0] dt_wdata,
  output logic          dt_ack,
  output logic [DW-1:0] dt_rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  localparam logic [1:0] C_NONE = 2'b00, C_READ = 2'b01, C_WRITE = 2'b10;
  state_t state;
  logic gnt_dt, wr, pick_dt;
  logic [1:0] cnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dt;
  // tie goes to whichever requester was not granted last
  always_comb pick_dt = dt_req & (~if_req | ~last_dt);
`else
  // data always wins a tie
  always_comb pick_dt = dt_req;
`endif
  // arbitration, access sequencing and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt_dt <= 1'b0;
      wr <= 1'b0;
      cnt <= 2'd0;
      mem_cmd <= C_NONE;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ack <= 1'b0;
      dt_ack <= 1'b0;
      if_rdata <= '0;
      dt_rdata <= '0;
      busy <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_dt <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: if (if_req | dt_req) begin
          state <= ACCESS;
          busy <= 1'b1;
          gnt_dt <= pick_dt;
          wr <= pick_dt & dt_wr;
          mem_addr <= pick_dt ? dt_addr : if_addr;
          mem_wdata <= (pick_dt & dt_wr) ? dt_wdata : mem_wdata;
          mem_cmd <= (pick_dt & dt_wr) ? C_WRITE : C_READ;
          cnt <= 2'(RD_LAT - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_dt <= pick_dt;
`endif
        end
        ACCESS: if (wr || cnt == 2'd0) begin
          state <= ACK;
          mem_cmd <= C_NONE;
          if_ack <= ~gnt_dt;
          dt_ack <= gnt_dt;
          if (!wr && gnt_dt) dt_rdata <= mem_rdata;
          if (!wr && !gnt_dt) if_rdata <= mem_rdata;
        end else begin
          cnt <= cnt - 2'd1;
        end
        ACK: begin
          state <= IDLE;
          if_ack <= 1'b0;
          dt_ack <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters: the CPU instruction-fetch stage (IF1/IF2) and the data-access stage (LDR/STR).
- Sits between the controller FSM and the RAM, and owns all memory sequencing.
- Arbitrates, latches address and data at grant, drives `mem_cmd` for the memory's read latency, captures read data, and returns a one-cycle ack to the winner.

Parameters:
- AW, 9, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until `if_ack`.
- if_addr  in  AW  fetch address (the PC).
- if_ack  out  1  one-cycle completion strobe to fetch.
- if_rdata  out  DW  fetched instruction; valid while `if_ack`=1, held afterwards.
- dt_req  in  1  data request; held high until `dt_ack`.
- dt_wr  in  1  1 = store, 0 = load.
- dt_addr  in  AW  data address.
- dt_wdata  in  DW  store data.
- dt_ack  out  1  one-cycle completion strobe to data.
- dt_rdata  out  DW  load data; valid while `dt_ack`=1, held afterwards.
- mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE; 11 never driven.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after READ is first driven.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, `mem_cmd`=NONE, `mem_addr`=0, `mem_wdata`=0, `if_ack`=`dt_ack`=0, `if_rdata`=`dt_rdata`=0, `busy`=0, `last_grant`=DATA.
- All outputs are registered.

State machine:
- IDLE: if any request is pending, arbitrate, then latch grant, address, `dt_wr` and `dt_wdata` → ACCESS, and load the latency counter with RD_LAT-1. Otherwise stay in IDLE.
- ACCESS, read: `mem_cmd`=READ, `mem_addr`=latched address, held RD_LAT cycles. On the last cycle, capture `mem_rdata` into the granted requester's rdata register → ACK.
- ACCESS, write: `mem_cmd`=WRITE with address and data for exactly 1 cycle → ACK.
- ACK: `mem_cmd`=NONE; assert exactly one of `if_ack`/`dt_ack` for 1 cycle → IDLE.

Timing:
- Read latency: `req` first seen in IDLE at cycle 0, ack at cycle RD_LAT+1. With RD_LAT=1, ack is 2 cycles after the sampling edge.
- Write latency: ack at cycle 2.

Protocol and arbitration rules:
- Requester deasserts `req` on the clock edge after it sees ack. A `req` still high in IDLE starts a new transaction.
- Arbitration with both requests high: `dt_req` wins (fixed priority).
- Address and data changes after grant are ignored.
- `req` dropping mid-transaction: the transaction still completes and ack is still issued.
- The fetch requester is read-only; `dt_wr` is ignored for a fetch grant.
- The non-granted rdata register keeps its value.
- Reset asserted mid-transaction: immediate return to reset values. Any pending WRITE is abandoned; the RAM contents at that address are unspecified.
- Back-to-back: IDLE always lasts at least 1 cycle between transactions; maximum throughput is one access per RD_LAT+2 cycles.

Optional Feature:
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- Defined: on a tie, the requester not in `last_grant` wins. `last_grant` updates at every grant; after reset the first tie goes to fetch.
- Undefined: fixed data priority; `last_grant` is not implemented.
- A lone request is granted immediately in both builds.

Test Plan:
- Reset: assert `reset` mid-READ with RD_LAT=1 → all outputs 0 within the same cycle; after release, `busy`=0 and `mem_cmd`=00.
- Fetch: `mem_rdata` returns 16'hD105 for address 9'h004; `if_req`=1, `if_addr`=9'h004 → `mem_cmd`=01 and `mem_addr`=004 for 1 cycle, then `if_ack`=1 with `if_rdata`=16'hD105 two cycles after sampling; `dt_ack` stays 0.
- Store: `dt_req`=1, `dt_wr`=1, `dt_addr`=9'h010, `dt_wdata`=16'h00AB → `mem_cmd`=10 for exactly 1 cycle with that address and data, then `dt_ack` for 1 cycle. A following load from 9'h010 returns 16'h00AB.
- Tie, fixed priority: `if_req` and `dt_req` rise together → data is serviced first; fetch is acked after the data transaction completes, with `busy` continuously high except the 1-cycle IDLE between them.
- Tie, `MEM_ARB_ROUND_ROBIN_EN` defined: both requests held continuously for 4 transactions → grant order is IF, DT, IF, DT.
- RD_LAT=3: fetch from 9'h001 → READ held 3 cycles, `if_ack` at cycle 4. Changing `if_addr` during ACCESS does not change `mem_addr`.
